// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with a level interrupt on a 16-byte bus window.
// Define TIMER_PRESCALE_EN to add the PRESCALE register at offset 3 and a tick prescaler.
module timer_dev #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset, count, ps_rd;
    logic        pend, tick, sel, wr, auto;
    logic [1:0]  off;

    assign sel  = Addr[31:4] == BASE[31:4];
    assign off  = Addr[3:2];
    assign wr   = WE & sel;
    assign auto = ctrl[2:1] == 2'b01;
    assign IRQ  = ctrl[3] & pend;
    assign Dout = !sel ? 32'd0 :
                  off == 2'd0 ? {28'd0, ctrl} :
                  off == 2'd1 ? preset :
                  off == 2'd2 ? count : ps_rd;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale, psc;
    assign tick  = psc == prescale;
    assign ps_rd = {16'd0, prescale};
    always_ff @(posedge clk) begin
        if (reset) begin
            prescale <= 16'd0;
            psc      <= 16'd0;
        end else begin
            if (wr && off == 2'd3) prescale <= Din[15:0];
            psc <= (state == CNT && !tick) ? psc + 16'd1 : 16'd0;
        end
    end
`else
    assign tick  = 1'b1;
    assign ps_rd = 32'd0;
`endif

    // Bus writes come last so they override FSM updates of EN and pend in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ctrl   <= 4'd0;
            preset <= 32'd0;
            count  <= 32'd0;
            pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (ctrl[0]) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                    if (auto) pend <= 1'b0;
                end
                CNT: begin
                    if (!ctrl[0]) state <= IDLE;
                    else if (tick && count <= 32'd1) begin
                        count <= 32'd0;
                        state <= INT;
                    end else if (tick) count <= count - 32'd1;
                end
                INT: begin
                    pend  <= 1'b1;
                    state <= auto ? LOAD : IDLE;
                    if (!auto) ctrl[0] <= 1'b0;
                end
            endcase
            if (wr && off == 2'd0) ctrl <= Din[3:0];
            if (wr && off == 2'd1) preset <= Din;
            if (wr && off <= 2'd1) pend <= 1'b0;
        end
    end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: randomized scenario checks of timer_dev against cycle-count arithmetic.
module tb_timer_dev;
    logic        clk = 1'b0, reset = 1'b0, WE = 1'b0, IRQ;
    logic [31:2] Addr = '0;
    logic [31:0] Din = '0, Dout;
    int          errors = 0, checks = 0;

    localparam logic [31:0] CTRL_A = 32'h7F00, PRE_A = 32'h7F04, CNT_A = 32'h7F08, PS_A = 32'h7F0C;

    timer_dev dut (.clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ));

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a[31:2];
        Din  = d;
        WE   = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a[31:2];
        WE   = 1'b0;
        #1;
        d = Dout;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        WE    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd(CTRL_A + 32'(4 * i), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL reset_read off%0d: got %0h want 0", i, d); end
        end
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_one_shot(input int p, input bit im);
        logic [31:0] d;
        logic        ei;
        int          e, pe;
        pe = p < 1 ? 1 : p;
        do_reset();
        wr(PRE_A, 32'(p));
        wr(CTRL_A, im ? 32'h9 : 32'h1);
        for (int k = 1; k <= pe + 6; k++) begin
            step(1);
            rd(CNT_A, d);
            e = k < 2 ? 0 : p - (k - 2);
            if (e < 0) e = 0;
            ei = im && (k >= pe + 3);
            checks++;
            if (d !== 32'(e)) begin errors++; $display("FAIL oneshot_count p=%0d k=%0d: got %0d want %0d", p, k, d, e); end
            checks++;
            if (IRQ !== ei) begin errors++; $display("FAIL oneshot_irq p=%0d im=%0d k=%0d: got %b want %b", p, im, k, IRQ, ei); end
        end
        rd(CTRL_A, d);
        checks++;
        if (d !== (im ? 32'h8 : 32'h0)) begin errors++; $display("FAIL oneshot_ctrl p=%0d: got %0h want %0h", p, d, im ? 8 : 0); end
        wr(CTRL_A, 32'h8);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_clear p=%0d im=%0d: got %b want 0", p, im, IRQ); end
            step(1);
        end
    endtask

    task automatic test_auto_reload(input int p);
        logic [31:0] d;
        logic        ei;
        int          e, pe, t, j, pulses;
        pe = p < 1 ? 1 : p;
        t = pe + 2;
        pulses = 0;
        do_reset();
        wr(PRE_A, 32'(p));
        wr(CTRL_A, 32'hB);
        for (int k = 1; k <= t * 5 + pe + 3; k++) begin
            step(1);
            rd(CNT_A, d);
            j = (k - 1) % t;
            e = j == 0 ? 0 : p - (j - 1);
            if (e < 0) e = 0;
            ei = (k >= pe + 3) && ((k - pe - 3) % t == 0);
            if (IRQ === 1'b1) pulses++;
            checks++;
            if (d !== 32'(e)) begin errors++; $display("FAIL auto_count p=%0d k=%0d: got %0d want %0d", p, k, d, e); end
            checks++;
            if (IRQ !== ei) begin errors++; $display("FAIL auto_irq p=%0d k=%0d: got %b want %b", p, k, IRQ, ei); end
        end
        checks++;
        if (pulses != 6) begin errors++; $display("FAIL auto_pulses p=%0d: got %0d want 6", p, pulses); end
    endtask

    task automatic test_en_stop(input int p, input int m);
        logic [31:0] d;
        int          h;
        h = p - m + 1;
        do_reset();
        wr(PRE_A, 32'(p));
        wr(CTRL_A, 32'h1);
        step(m);
        wr(CTRL_A, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd(CNT_A, d);
            checks++;
            if (d !== 32'(h)) begin errors++; $display("FAIL stop_hold p=%0d m=%0d: got %0d want %0d", p, m, d, h); end
            step(1);
        end
        rd(CTRL_A, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL stop_ctrl: got %0h want 0", d); end
        wr(CTRL_A, 32'h1);
        step(1);
        rd(CNT_A, d);
        checks++;
        if (d !== 32'(h)) begin errors++; $display("FAIL stop_rearm_hold: got %0d want %0d", d, h); end
        step(1);
        rd(CNT_A, d);
        checks++;
        if (d !== 32'(p)) begin errors++; $display("FAIL stop_reload: got %0d want %0d", d, p); end
    endtask

    task automatic test_ignored_writes(input int p);
        logic [31:0] d;
        do_reset();
        wr(PRE_A, 32'(p));
        wr(CTRL_A, 32'h1);
        step(3);
        wr(CNT_A, $urandom);
        rd(CNT_A, d);
        checks++;
        if (d !== 32'(p - 2)) begin errors++; $display("FAIL count_write: got %0d want %0d", d, p - 2); end
        wr(32'h7F10, $urandom & 32'hFFFF_FFF0);
        rd(CNT_A, d);
        checks++;
        if (d !== 32'(p - 3)) begin errors++; $display("FAIL outside_count: got %0d want %0d", d, p - 3); end
        rd(CTRL_A, d);
        checks++;
        if (d !== 32'h1) begin errors++; $display("FAIL outside_ctrl: got %0h want 1", d); end
        rd(PRE_A, d);
        checks++;
        if (d !== 32'(p)) begin errors++; $display("FAIL outside_preset: got %0d want %0d", d, p); end
        rd(32'h7F10, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL outside_read: got %0h want 0", d); end
        wr(PRE_A, 32'(p + 100));
        rd(CNT_A, d);
        checks++;
        if (d !== 32'(p - 4)) begin errors++; $display("FAIL preset_midcount: got %0d want %0d", d, p - 4); end
    endtask

    task automatic test_int_conflict(input int p);
        logic [31:0] d;
        do_reset();
        wr(PRE_A, 32'(p));
        wr(CTRL_A, 32'h9);
        step(p + 2);
        wr(CTRL_A, 32'h9);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL conflict_irq p=%0d: got %b want 0", p, IRQ); end
        rd(CTRL_A, d);
        checks++;
        if (d !== 32'h9) begin errors++; $display("FAIL conflict_ctrl p=%0d: got %0h want 9", p, d); end
        step(2);
        rd(CNT_A, d);
        checks++;
        if (d !== 32'(p)) begin errors++; $display("FAIL conflict_rearm p=%0d: got %0d want %0d", p, d, p); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        do_reset();
        wr(PRE_A, 32'd50);
        wr(CTRL_A, 32'hB);
        step(10);
        reset = 1'b1;
        Addr  = CTRL_A[31:2];
        Din   = 32'hF;
        WE    = 1'b1;
        @(posedge clk);
        #1;
        WE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(CTRL_A + 32'(4 * i), d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL midreset off%0d: got %0h want 0", i, d); end
        end
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL midreset_irq: got %b want 0", IRQ); end
        reset = 1'b0;
    endtask

    task automatic test_prescale();
        logic [31:0] d;
        do_reset();
        wr(PS_A, 32'hFFFF_FFFF);
        rd(PS_A, d);
`ifdef TIMER_PRESCALE_EN
        checks++;
        if (d !== 32'h0000_FFFF) begin errors++; $display("FAIL prescale_rw: got %0h want ffff", d); end
        wr(PS_A, 32'd2);
        wr(PRE_A, 32'd2);
        wr(CTRL_A, 32'h1);
        for (int k = 1; k <= 10; k++) begin
            int e;
            step(1);
            rd(CNT_A, d);
            e = k < 2 ? 0 : 2 - (k - 2) / 3;
            if (e < 0) e = 0;
            checks++;
            if (d !== 32'(e)) begin errors++; $display("FAIL prescale_count k=%0d: got %0d want %0d", k, d, e); end
        end
`else
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reserved_off3: got %0h want 0", d); end
`endif
    endtask

    initial begin
        test_reset();
        test_one_shot(5, 1'b1);
        test_one_shot(5, 1'b0);
        test_one_shot(0, 1'b1);
        repeat (3) test_one_shot($urandom_range(0, 12), 1'($urandom_range(0, 1)));
        test_auto_reload(3);
        test_auto_reload(0);
        test_auto_reload($urandom_range(1, 9));
        test_en_stop(20, 14);
        begin
            int p;
            p = $urandom_range(10, 30);
            test_en_stop(p, $urandom_range(3, p - 2));
        end
        test_ignored_writes($urandom_range(12, 40));
        test_int_conflict(3);
        test_int_conflict($urandom_range(1, 8));
        test_reset_mid();
        test_prescale();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
